// File: rtl/free_list_if.sv
// Decode/commit/flush bundle for the physical-register free list.
// master: decode+ROB side driving requests; slave: the free list responding.
interface free_list_if #(
    parameter int PRF_DEPTH = 64,
    parameter int FL_DEPTH  = 32
);
    localparam int PW = $clog2(PRF_DEPTH);
    localparam int CW = $clog2(FL_DEPTH) + 1;

    logic          id_dequeue;
    logic          fl_ready;
    logic [PW-1:0] fl_preg;
    logic          commit_valid;
    logic [PW-1:0] commit_preg;
    logic          flush;
    logic [CW-1:0] free_count;

    modport master (
        output id_dequeue,
        output commit_valid,
        output commit_preg,
        output flush,
        input  fl_ready,
        input  fl_preg,
        input  free_count
    );

    modport slave (
        input  id_dequeue,
        input  commit_valid,
        input  commit_preg,
        input  flush,
        output fl_ready,
        output fl_preg,
        output free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for rename.
// Ports: clk, rst (async high), fl (slave: dequeue/commit/flush in, ready/preg/count out).
module free_list #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_DEPTH = 32,
    parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH
) (
    input logic        clk,
    input logic        rst,
    free_list_if.slave fl
);
    localparam int PW = $clog2(PRF_DEPTH);
    localparam int IW = $clog2(FL_DEPTH);
    localparam int CW = IW + 1;

    logic [PW-1:0] storage [FL_DEPTH];
    logic [CW-1:0] head;
    logic [CW-1:0] tail;
    logic [CW-1:0] head_nxt;
    logic [CW-1:0] tail_nxt;
    logic          empty;
    logic          full;
    logic          do_deq;
    logic          do_enq;

    assign empty = (head == tail);
    assign full  = (head[IW-1:0] == tail[IW-1:0]) &&
                   (head[IW] != tail[IW]);

    assign do_deq = fl.id_dequeue && !empty && !fl.flush;
    // A full list only accepts a release when a dequeue frees the slot.
    assign do_enq = fl.commit_valid && (!full || do_deq);

    always_comb begin
        tail_nxt = tail + CW'(do_enq);
        head_nxt = head + CW'(do_deq);
        // Recovery: everything between the post-enqueue tail and the old
        // head is an in-flight allocation, so handing it all back means
        // placing head one full lap behind tail.
        if (fl.flush) begin
            head_nxt = {~tail_nxt[IW], tail_nxt[IW-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= {1'b1, {IW{1'b0}}};
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                storage[i] <= PW'(ARF_DEPTH + i);
            end
        end else if (do_enq) begin
            storage[tail[IW-1:0]] <= fl.commit_preg;
        end
    end

    assign fl.fl_ready   = !empty;
    assign fl.fl_preg    = storage[head[IW-1:0]];
    assign fl.free_count = tail - head;
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_free_list;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    free_list_if #(.PRF_DEPTH(64), .FL_DEPTH(32)) ifc ();

    free_list #(.PRF_DEPTH(64), .ARF_DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(ifc.commit_valid && ifc.free_count == 6'd32 &&
                      !(ifc.id_dequeue && !ifc.flush)))
            else $error("FAIL protocol: enqueue while full");
        end
    end

    // Reference model: avail is the list in FIFO order; alloc holds the
    // handed-out tags oldest first, which is what a flush gives back.
    int avail[$];
    int alloc[$];

    typedef struct {
        bit deq;
        bit cv;
        int cp;
        bit fl;
        bit ready;
        int preg;
        int count;
    } vec_t;

    vec_t vecs[9];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        avail.delete();
        alloc.delete();
        for (int i = 0; i < 32; i++) avail.push_back(32 + i);
    endtask

    task automatic model_step(bit d, bit cv, int cp, bit f);
        if (d && avail.size() > 0 && !f) alloc.push_back(avail.pop_front());
        if (cv && avail.size() < 32) begin
            avail.push_back(cp);
            void'(alloc.pop_front());
        end
        if (f) begin
            avail = {alloc, avail};
            alloc.delete();
        end
    endtask

    task automatic model_check(string tag);
        check({tag, " ready"}, 32'(ifc.fl_ready), 32'(avail.size() > 0));
        check({tag, " count"}, 32'(ifc.free_count), 32'(avail.size()));
        if (avail.size() > 0) begin
            check({tag, " preg"}, 32'(ifc.fl_preg), 32'(avail[0]));
        end
    endtask

    task automatic idle();
        ifc.id_dequeue   = 1'b0;
        ifc.commit_valid = 1'b0;
        ifc.commit_preg  = '0;
        ifc.flush        = 1'b0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(bit d, bit cv, int cp, bit f);
        ifc.id_dequeue   = d;
        ifc.commit_valid = cv;
        ifc.commit_preg  = 6'(cp);
        ifc.flush        = f;
        #1;
        model_check("pre");
        model_step(d, cv, cp, f);
        @(posedge clk);
        #1;
        model_check("post");
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        model_check("reset");
    endtask

    initial begin
        int exp_q[$];
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();

        vecs[0] = '{1, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 5, 0, 1, 5, 1};
        vecs[2] = '{1, 1, 9, 0, 1, 9, 1};
        vecs[3] = '{1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{0, 1, 7, 0, 1, 7, 1};
        vecs[5] = '{0, 1, 8, 0, 1, 7, 2};
        vecs[6] = '{1, 0, 0, 0, 1, 8, 1};
        vecs[7] = '{0, 0, 0, 1, 1, 36, 32};
        vecs[8] = '{1, 0, 0, 1, 1, 36, 32};

        // Reset image and drain.
        do_reset();
        check("reset count", 32'(ifc.free_count), 32);
        check("reset preg", 32'(ifc.fl_preg), 32);
        check("reset ready", 32'(ifc.fl_ready), 1);
        for (int i = 0; i < 32; i++) begin
            check("drain preg", 32'(ifc.fl_preg), 32'(32 + i));
            check("drain count", 32'(ifc.free_count), 32'(32 - i));
            cycle(1, 0, 0, 0);
        end
        check("empty ready", 32'(ifc.fl_ready), 0);
        check("empty count", 32'(ifc.free_count), 0);

        // Table: empty dequeue, enqueue visibility, count=1 swap, flush.
        for (int k = 0; k < 9; k++) begin
            cycle(vecs[k].deq, vecs[k].cv, vecs[k].cp, vecs[k].fl);
            check("vec ready", 32'(ifc.fl_ready), 32'(vecs[k].ready));
            check("vec count", 32'(ifc.free_count), 32'(vecs[k].count));
            if (vecs[k].ready) begin
                check("vec preg", 32'(ifc.fl_preg), 32'(vecs[k].preg));
            end
        end

        // Full list: dequeue plus commit keeps count, 40 lands at the end.
        do_reset();
        cycle(1, 1, 40, 0);
        check("full swap count", 32'(ifc.free_count), 32);
        repeat (31) cycle(1, 0, 0, 0);
        check("full swap preg", 32'(ifc.fl_preg), 40);

        // Three laps of wrap-around.
        do_reset();
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0);
            for (int i = 0; i < 32; i++) cycle(0, 1, (lap * 11 + i * 7) % 64, 0);
            check("lap head", 32'(ifc.fl_preg), 32'((lap * 11) % 64));
        end

        // Flush recovery.
        do_reset();
        repeat (10) cycle(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 1, i, 0);
        cycle(0, 1, 6, 1);
        check("flush count", 32'(ifc.free_count), 32);
        check("flush preg", 32'(ifc.fl_preg), 37);
        for (int i = 37; i < 64; i++) exp_q.push_back(i);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(6);
        foreach (exp_q[k]) begin
            check("flush order", 32'(ifc.fl_preg), 32'(exp_q[k]));
            cycle(1, 0, 0, 0);
        end

        // Async reset between edges.
        do_reset();
        repeat (25) cycle(1, 0, 0, 0);
        check("pre-rst count", 32'(ifc.free_count), 7);
        #3;
        rst = 1'b1;
        #1;
        check("async count", 32'(ifc.free_count), 32);
        check("async preg", 32'(ifc.fl_preg), 32);
        check("async ready", 32'(ifc.fl_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        model_check("after async");

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bit d;
            bit cv;
            bit f;
            int cp;
            d  = 1'($urandom_range(0, 1));
            cv = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 31) == 0);
            cp = int'($urandom_range(0, 63));
            if (cv && avail.size() == 32 && !(d && !f)) cv = 1'b0;
            cycle(d, cv, cp, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
